// File: rtl/lut_cfg_pkg.sv
// lut_cfg_pkg: shared FSM states, geometry helpers and host entry-packing convention
package lut_cfg_pkg;
  typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;
  function automatic int epw(input int word_w, input int out_bits);
    return word_w / out_bits;
  endfunction
  function automatic int beats(input int in_bits, input int word_w, input int out_bits);
    return (2 ** in_bits) / epw(word_w, out_bits);
  endfunction
  function automatic int cnt_w(input int n_beats);
    return n_beats > 1 ? $clog2(n_beats) : 1;
  endfunction
  function automatic int entry_lsb(input int e, input int out_bits);
    return e * out_bits;
  endfunction
endpackage

// File: rtl/lut_dist_ram.sv
// lut_dist_ram: distributed truth-table RAM, beat-wide write port, registered read port
module lut_dist_ram
  import lut_cfg_pkg::*;
#(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 1,
  parameter int EPW      = 8,
  parameter int BW       = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [BW-1:0]           wbeat,
  input  logic [EPW*OUT_BITS-1:0] wdata,
  input  logic                    re,
  input  logic [IN_BITS-1:0]      raddr,
  output logic [OUT_BITS-1:0]     rdata
);
  (* ram_style = "distributed" *) logic [OUT_BITS-1:0] mem [2**IN_BITS];
  // write all entries of one beat; table contents survive reset
  always_ff @(posedge clk) begin
    if (we)
      for (int e = 0; e < EPW; e++)
        mem[IN_BITS'(int'(wbeat) * EPW + e)] <= wdata[entry_lsb(e, OUT_BITS) +: OUT_BITS];
  end
  // registered lookup; nonblocking write above gives read-before-write
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/lut_neuron_loader.sv
// lut_neuron_loader: streams a truth table from the config bus and serves lookups from it
module lut_neuron_loader
  import lut_cfg_pkg::*;
#(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 1,
  parameter int WORD_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [WORD_W-1:0]   cfg_data,
  input  logic                cfg_last,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data,
  output logic                tbl_valid,
  output logic                load_err
);
  localparam int EPW   = epw(WORD_W, OUT_BITS);
  localparam int BEATS = beats(IN_BITS, WORD_W, OUT_BITS);
  localparam int CW    = cnt_w(BEATS);
  state_t state, state_n;
  logic [CW-1:0] cnt, beat;
  logic cfg_acc, in_acc, final_beat, done, bad;
  assign beat       = state == LOAD ? cnt : '0;
  assign final_beat = beat == CW'(BEATS - 1);
  assign cfg_acc    = cfg_valid && cfg_ready;
  assign in_acc     = in_valid && in_ready;
  assign done       = cfg_acc && cfg_last && final_beat;
  assign bad        = cfg_acc && (cfg_last != final_beat);
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else state <= state_n;
  end
  // any accepted beat leads into LOAD unless it completes or breaks the load
  always_comb begin
    state_n = !cfg_acc ? state : done ? READY : bad ? EMPTY : LOAD;
  end
  // lookups only against a complete table
  always_comb begin
    in_ready  = state == READY;
    tbl_valid = state == READY;
  end
  // beat counter restarts after every completed or aborted load
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (cfg_acc) cnt <= (done || bad) ? '0 : beat + CW'(1);
  end
  // sticky error, cleared by the first beat of the next load
  always_ff @(posedge clk) begin
    if (rst) load_err <= 1'b0;
    else if (bad) load_err <= 1'b1;
    else if (cfg_acc && state != LOAD) load_err <= 1'b0;
  end
  // config port held off during reset, always open afterwards
  always_ff @(posedge clk) begin
    if (rst) cfg_ready <= 1'b0;
    else cfg_ready <= 1'b1;
  end
  // one-cycle result strobe following each lookup handshake
  always_ff @(posedge clk) begin
    if (rst) out_valid <= 1'b0;
    else out_valid <= in_acc;
  end
  lut_dist_ram #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .EPW(EPW), .BW(CW)) u_ram (
    .clk(clk), .rst(rst), .we(cfg_acc), .wbeat(beat), .wdata(cfg_data),
    .re(in_acc), .raddr(in_data), .rdata(out_data)
  );
endmodule

// File: tb/tb_lut_neuron_loader.sv
// tb_lut_neuron_loader: directed vectors, corner sequences and random run against a model
module tb_lut_neuron_loader;
  logic clk = 1'b0, rst = 1'b1;
  logic cfg_valid = 1'b0, cfg_ready, cfg_last = 1'b0;
  logic [7:0] cfg_data = '0;
  logic in_valid = 1'b0, in_ready;
  logic [5:0] in_data = '0;
  logic out_valid, tbl_valid, load_err;
  logic [0:0] out_data;
  int n_chk = 0, n_fail = 0;
  typedef struct {logic [5:0] addr; logic exp;} vec_t;
  vec_t vecs[12];
  logic ov, od;
  logic [7:0] pat;
  logic m_mem[64];
  int m_state, m_cnt, m_b;
  logic m_err, m_ov, m_od;
  lut_neuron_loader dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .cfg_last(cfg_last), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .tbl_valid(tbl_valid), .load_err(load_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [7:0] d, input logic l);
    cfg_valid = 1'b1; cfg_data = d; cfg_last = l;
    step();
    cfg_valid = 1'b0; cfg_last = 1'b0;
  endtask
  task automatic load_all(input logic [7:0] d0, input logic [7:0] d);
    beat(d0, 1'b0);
    for (int i = 1; i < 7; i++) beat(d, 1'b0);
    beat(d, 1'b1);
  endtask
  task automatic lookup(input logic [5:0] a, output logic v, output logic o);
    in_valid = 1'b1; in_data = a;
    step();
    in_valid = 1'b0;
    v = out_valid; o = out_data[0];
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask
  initial begin
    vecs = '{'{6'd0, 1'b0}, '{6'd1, 1'b1}, '{6'd2, 1'b1}, '{6'd3, 1'b0},
             '{6'd4, 1'b1}, '{6'd5, 1'b0}, '{6'd6, 1'b0}, '{6'd7, 1'b1},
             '{6'd13, 1'b0}, '{6'd58, 1'b1}, '{6'd63, 1'b1}, '{6'd40, 1'b0}};
    step();
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_tbl_valid", tbl_valid, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    step();
    chk("post_rst_cfg_ready", cfg_ready, 1);
    // 1: uniform 0x96 table
    load_all(8'h96, 8'h96);
    chk("t1_tbl_valid", tbl_valid, 1);
    chk("t1_in_ready", in_ready, 1);
    for (int i = 0; i < 12; i++) begin
      lookup(vecs[i].addr, ov, od);
      chk($sformatf("t1_vec%0d_valid", i), ov, 1);
      chk($sformatf("t1_vec%0d_data", i), od, vecs[i].exp);
    end
    pat = 8'h96;
    for (int a = 0; a < 64; a++) begin
      lookup(6'(a), ov, od);
      chk($sformatf("t1_sweep%0d", a), {ov, od}, {1'b1, pat[a % 8]});
    end
    step();
    chk("t1_valid_pulse", out_valid, 0);
    // 2: early cfg_last
    for (int i = 0; i < 3; i++) beat(8'h00, 1'b0);
    beat(8'h00, 1'b1);
    chk("t2_load_err", load_err, 1);
    chk("t2_tbl_valid", tbl_valid, 0);
    chk("t2_in_ready", in_ready, 0);
    beat(8'h0F, 1'b0);
    chk("t2_err_cleared", load_err, 0);
    for (int i = 1; i < 7; i++) beat(8'h0F, 1'b0);
    beat(8'h0F, 1'b1);
    chk("t2_reload_valid", {tbl_valid, load_err}, 2'b10);
    // 3: missing cfg_last
    for (int i = 0; i < 8; i++) beat(8'h00, 1'b0);
    chk("t3_load_err", load_err, 1);
    chk("t3_empty", {tbl_valid, in_ready}, 2'b00);
    load_all(8'hFF, 8'h00);
    chk("t3_restart_valid", {tbl_valid, load_err}, 2'b10);
    lookup(6'd3, ov, od);
    chk("t3_beat0_entry", {ov, od}, 2'b11);
    lookup(6'd9, ov, od);
    chk("t3_beat1_entry", {ov, od}, 2'b10);
    // 4: lookup in the same cycle as a reload beat
    load_all(8'h21, 8'h21);
    in_valid = 1'b1; in_data = 6'd5;
    beat(8'h00, 1'b0);
    in_valid = 1'b0;
    chk("t4_old_result", {out_valid, out_data}, 2'b11);
    chk("t4_tbl_dropped", {tbl_valid, in_ready}, 2'b00);
    for (int i = 1; i < 7; i++) beat(8'h00, 1'b0);
    beat(8'h00, 1'b1);
    lookup(6'd5, ov, od);
    chk("t4_new_result", {ov, od}, 2'b10);
    // 5: reset in the middle of a load
    for (int i = 0; i < 5; i++) beat(8'hAA, 1'b0);
    rst = 1'b1;
    step();
    chk("t5_rst_outputs", {tbl_valid, out_valid, in_ready, cfg_ready}, 4'b0000);
    rst = 1'b0;
    step();
    beat(8'hAA, 1'b0);
    chk("t5_no_resume", tbl_valid, 0);
    for (int i = 1; i < 7; i++) beat(8'hAA, 1'b0);
    beat(8'hAA, 1'b1);
    chk("t5_reload_valid", tbl_valid, 1);
    lookup(6'd17, ov, od);
    chk("t5_lookup", {ov, od}, 2'b11);
    // 6: random traffic against a reference model
    do_reset();
    m_state = 0; m_cnt = 0; m_err = 1'b0; m_ov = 1'b0; m_od = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      m_b = (m_state == 1) ? m_cnt : 0;
      cfg_valid = 1'($urandom_range(0, 1));
      cfg_data = 8'($urandom);
      cfg_last = (m_b == 7) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 11) == 0);
      in_valid = 1'($urandom_range(0, 1));
      in_data = 6'($urandom);
      m_ov = in_valid && m_state == 2;
      if (m_ov) m_od = m_mem[in_data];
      if (cfg_valid) begin
        for (int e = 0; e < 8; e++) m_mem[m_b * 8 + e] = cfg_data[e];
        if (m_state != 1) m_err = 1'b0;
        if (cfg_last && m_b == 7) begin m_state = 2; m_cnt = 0; end
        else if (cfg_last || m_b == 7) begin m_state = 0; m_cnt = 0; m_err = 1'b1; end
        else begin m_state = 1; m_cnt = m_b + 1; end
      end
      step();
      chk($sformatf("t6_cycle%0d", c),
          {cfg_ready, out_valid, out_valid & out_data[0], tbl_valid, in_ready, load_err},
          {1'b1, m_ov, m_ov & m_od, m_state == 2, m_state == 2, m_err});
    end
    cfg_valid = 1'b0; in_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
